ascii_tile_sched: RTL

Scheduler and accumulator controller for the ASCII-art video path. It walks the active VGA raster in 16×16-pixel tiles and sums each tile's 4-bit pixel values across 16 lines using a 40-entry column accumulator bank. When a tile completes, it emits the tile average (0–15 glyph select) and its tile address to the character-map writer through a valid/ready port. It sits between the pixel-value source and the character map that feeds the glyph renderer.

---
 rtl/ascii_pkg.sv | 35 +++
 rtl/char_wr_fifo.sv | 78 +++++++
 rtl/ascii_tile_sched.sv | 132 +++++++++++++
 3 files changed

// File: rtl/ascii_pkg.sv
// ascii_pkg: shared constants and types for the ASCII-art tile scheduler.
//   H_ACTIVE / V_ACTIVE / TILE_LOG2 : default raster and tile geometry
//   TILES_X / TILES_Y               : tile grid dimensions (40 x 30)
//   TILE_ADDR_W / ACC_W             : tile address and tile-sum widths
//   state_e                         : scheduler FSM states
//   char_entry_t                    : one character-map write {addr, data}
//   tile_avg()                      : tile sum -> 0..15 glyph select
package ascii_pkg;

  localparam int H_ACTIVE    = 640;
  localparam int V_ACTIVE    = 480;
  localparam int TILE_LOG2   = 4;
  localparam int TILE        = 1 << TILE_LOG2;
  localparam int TILES_X     = H_ACTIVE / TILE;
  localparam int TILES_Y     = V_ACTIVE / TILE;
  localparam int TILE_ADDR_W = $clog2(TILES_X * TILES_Y);
  // 256 pixels of up to 15 each: 3840 fits in 12 bits without saturation.
  localparam int ACC_W       = 2 * TILE_LOG2 + 4;

  typedef enum logic [0:0] {
    WAIT_SOF = 1'b0,
    RUN      = 1'b1
  } state_e;

  typedef struct packed {
    logic [TILE_ADDR_W-1:0] addr;
    logic [3:0]             data;
  } char_entry_t;

  // Average over a full tile is sum / 256, i.e. the top four bits of the sum.
  function automatic logic [3:0] tile_avg(input logic [ACC_W-1:0] sum);
    return sum[ACC_W-1 -: 4];
  endfunction

endpackage

// File: rtl/char_wr_fifo.sv
// char_wr_fifo: two-entry FIFO between the tile scheduler and the
// character-map writer. Slot 0 is always the head, so the read port is a
// plain register output.
//   vga_clk, rst             : clock, asynchronous active-high reset
//   push, push_addr/data     : new entry; ignored when full with no pop
//   rd_valid/rd_ready        : valid/ready read handshake
//   rd_addr, rd_data         : head entry
//   full                     : both slots occupied
module char_wr_fifo
  import ascii_pkg::*;
(
  input  logic                   vga_clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [TILE_ADDR_W-1:0] push_addr,
  input  logic [3:0]             push_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [TILE_ADDR_W-1:0] rd_addr,
  output logic [3:0]             rd_data,
  output logic                   full
);

  char_entry_t slot_q [2];
  char_entry_t slot_d [2];
  char_entry_t new_e;
  logic [1:0]  count_q, count_d;
  logic        pop;

  always_comb begin
    new_e   = '{addr: push_addr, data: push_data};
    pop     = (count_q != 2'd0) && rd_ready;
    slot_d  = slot_q;
    count_d = count_q;
    case ({push, pop})
      2'b11: begin
        // Pop frees the head first, so a push into a full FIFO still lands.
        if (count_q == 2'd2) begin
          slot_d[0] = slot_q[1];
          slot_d[1] = new_e;
        end else begin
          slot_d[0] = new_e;
        end
      end
      2'b10: begin
        if (count_q == 2'd0) begin
          slot_d[0] = new_e;
          count_d   = 2'd1;
        end else if (count_q == 2'd1) begin
          slot_d[1] = new_e;
          count_d   = 2'd2;
        end
      end
      2'b01: begin
        slot_d[0] = slot_q[1];
        count_d   = count_q - 2'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      count_q   <= 2'd0;
    end else begin
      slot_q  <= slot_d;
      count_q <= count_d;
    end
  end

  assign rd_valid = (count_q != 2'd0);
  assign rd_addr  = slot_q[0].addr;
  assign rd_data  = slot_q[0].data;
  assign full     = (count_q == 2'd2);

endmodule

// File: rtl/ascii_tile_sched.sv
// ascii_tile_sched: walks the active raster in TILE x TILE tiles, sums each
// tile's 4-bit pixels and emits {tile address, tile average} to the
// character-map writer.
//   vga_clk, rst                    : pixel clock, async active-high reset
//   pix_val, video_on               : pixel value, active-region qualifier
//   pixel_row, pixel_column         : raster coordinates of pix_val
//   char_wr_valid/ready/addr/data   : tile result handshake
//   frame_done                      : pulse when the last tile is pushed
//   overflow                        : sticky, a tile result was dropped
module ascii_tile_sched #(
  parameter int H_ACTIVE  = ascii_pkg::H_ACTIVE,
  parameter int V_ACTIVE  = ascii_pkg::V_ACTIVE,
  parameter int TILE_LOG2 = ascii_pkg::TILE_LOG2
) (
  input  logic        vga_clk,
  input  logic        rst,
  input  logic [3:0]  pix_val,
  input  logic        video_on,
  input  logic [11:0] pixel_row,
  input  logic [11:0] pixel_column,
  output logic        char_wr_valid,
  input  logic        char_wr_ready,
  output logic [10:0] char_wr_addr,
  output logic [3:0]  char_wr_data,
  output logic        frame_done,
  output logic        overflow
);

  import ascii_pkg::*;

  localparam int TX    = H_ACTIVE >> TILE_LOG2;
  localparam int TY    = V_ACTIVE >> TILE_LOG2;
  localparam int COL_W = (TX > 1) ? $clog2(TX) : 1;
  localparam int ROW_W = (TY > 1) ? $clog2(TY) : 1;
  localparam logic [TILE_ADDR_W-1:0] LAST_ADDR = TILE_ADDR_W'(TX * TY - 1);
  localparam logic [TILE_LOG2-1:0]   SUB_LAST  = '1;

  state_e                 state_q, state_d;
  logic [7:0]             strip_q, strip_d;
  logic [ACC_W-1:0]       acc_q [TX];
  logic [ACC_W-1:0]       acc_d [TX];
  logic                   overflow_q, overflow_d;
  logic                   frame_done_q, frame_done_d;

  logic                   sof, active;
  logic [TILE_LOG2-1:0]   sx, sy;
  logic [COL_W-1:0]       tile_col;
  logic [ROW_W-1:0]       tile_row;
  logic [7:0]             full_strip;
  logic [ACC_W-1:0]       acc_sum;
  logic                   push, pop, push_drop, fifo_full;
  logic [TILE_ADDR_W-1:0] push_addr;
  logic [3:0]             push_data;

  always_comb begin
    sof      = video_on && (pixel_row == 12'd0) && (pixel_column == 12'd0);
    // The SOF pixel itself is processed even though the FSM is still waiting.
    active   = video_on && ((state_q == RUN) || sof);
    sx       = pixel_column[TILE_LOG2-1:0];
    sy       = pixel_row[TILE_LOG2-1:0];
    tile_col = pixel_column[TILE_LOG2 +: COL_W];
    tile_row = pixel_row[TILE_LOG2 +: ROW_W];

    full_strip = strip_q + {4'b0000, pix_val};
    acc_sum    = acc_q[tile_col] + ACC_W'(full_strip);
    push_addr  = TILE_ADDR_W'(tile_row) * TILE_ADDR_W'(TX) + TILE_ADDR_W'(tile_col);
    push_data  = tile_avg(acc_sum);
    push       = active && (sx == SUB_LAST) && (sy == SUB_LAST);
    pop        = char_wr_valid && char_wr_ready;
    push_drop  = push && fifo_full && !pop;

    state_d      = state_q;
    strip_d      = strip_q;
    acc_d        = acc_q;
    overflow_d   = overflow_q;
    frame_done_d = push && (push_addr == LAST_ADDR);

    if (sof) begin
      state_d = RUN;
    end

    if (active) begin
      strip_d = (sx == '0) ? {4'b0000, pix_val} : full_strip;
      // The first line of a band overwrites the column, so a partial band
      // left by a resync or reset never leaks into the next tile.
      if (sx == SUB_LAST) begin
        acc_d[tile_col] = (sy == '0) ? ACC_W'(full_strip) : acc_sum;
      end
    end

    if (sof) begin
      overflow_d = 1'b0;
    end else if (push_drop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      state_q      <= WAIT_SOF;
      strip_q      <= 8'd0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < TX; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      strip_q      <= strip_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
      acc_q        <= acc_d;
    end
  end

  char_wr_fifo u_fifo (
    .vga_clk   (vga_clk),
    .rst       (rst),
    .push      (push),
    .push_addr (push_addr),
    .push_data (push_data),
    .rd_valid  (char_wr_valid),
    .rd_ready  (char_wr_ready),
    .rd_addr   (char_wr_addr),
    .rd_data   (char_wr_data),
    .full      (fifo_full)
  );

  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

endmodule
